// File: rtl/divider_pkg.sv
// Shared constants and FSM encoding for the divider packet controller.
// Result tags, tag-field bit positions and the controller state enum.
package divider_pkg;

    localparam logic [15:0] TAG_Q   = 16'h000a;
    localparam logic [15:0] TAG_R   = 16'h000b;
    localparam logic [15:0] TAG_DZ  = 16'h000d;
    localparam logic [15:0] TAG_ERR = 16'h000e;

    // Operand tag layout: tag[11:8] = extension mode, tag[12] = signed.
    localparam int MODE_LSB = 8;
    localparam int MODE_MSB = 11;
    localparam int SIGN_BIT = 12;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_EMIT    = 3'd5
    } state_e;

endpackage

// File: rtl/divider_req_fifo.sv
// Show-ahead synchronous request FIFO (W x DEPTH, DEPTH a power of two).
// Push while full is accepted only when a pop happens in the same cycle.
module divider_req_fifo
    import divider_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/divider_packet_ctrl.sv
// Packet controller: queues 2-operand requests, extends operands, runs the divider core.
// Optional WAIT-state watchdog is enabled by defining DIV_TIMEOUT_EN.
module divider_packet_ctrl
    import divider_pkg::*;
#(
    parameter int DW          = 32,
    parameter int TAG_W       = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int DIV_TIMEOUT = 64,
    localparam int PKT_W      = 2 * (TAG_W + DW)
) (
    input  logic             divider_clk,
    input  logic             divider_rst,
    input  logic             write,
    input  logic [PKT_W-1:0] out_data,
    output logic             in_full,
    output logic             overflow,
    output logic             i_call,
    output logic             reset_n,
    output logic [DW-1:0]    num_data,
    output logic [DW-1:0]    dem_data,
    input  logic [DW-1:0]    o_x,
    input  logic [DW-1:0]    o_y,
    input  logic             div_done,
    output logic             write_in,
    output logic [PKT_W-1:0] write_out,
    input  logic             out_ready,
    output logic [2:0]       dbg_state_o
);

    state_e           state_q;
    logic             i_call_q;
    logic             reset_n_q;
    logic             write_in_q;
    logic             overflow_q;
    logic [DW-1:0]    num_q;
    logic [DW-1:0]    den_q;
    logic [PKT_W-1:0] write_out_q;

    logic [PKT_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign push = write && !fifo_full;
    assign pop  = (state_q == ST_LOAD);

    divider_req_fifo #(
        .W     (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (divider_clk),
        .rst_i   (divider_rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (out_data),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    logic [TAG_W-1:0] tag_d;
    logic [TAG_W-1:0] tag_n;
    logic [DW-1:0]    den_raw;
    logic [DW-1:0]    num_raw;
    logic             tag_unused;

    assign {tag_d, den_raw, tag_n, num_raw} = head;
    assign tag_unused = ^{tag_d, tag_n};

    function automatic logic mode_ok(input logic [3:0] m);
        return (m != 4'd0) && (int'(m) <= DW / 8);
    endfunction

    // Keep the low 8*m bits, fill above with zero or the selected MSB.
    function automatic logic [DW-1:0] extend(input logic [DW-1:0] v, input logic [3:0] m,
                                             input logic sgn);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 1; k <= DW / 8; k++) begin
            if (int'(m) == k) begin
                for (int b = 0; b < DW; b++) begin
                    r[b] = (b < 8 * k) ? v[b] : (sgn & v[8*k-1]);
                end
            end
        end
        return r;
    endfunction

    logic [3:0]    mode_n;
    logic [3:0]    mode_d;
    logic          bad_req;
    logic [DW-1:0] num_ext;
    logic [DW-1:0] den_ext;

    assign mode_n  = tag_n[MODE_MSB:MODE_LSB];
    assign mode_d  = tag_d[MODE_MSB:MODE_LSB];
    assign bad_req = !mode_ok(mode_n) || !mode_ok(mode_d);
    assign num_ext = extend(num_raw, mode_n, tag_n[SIGN_BIT]);
    assign den_ext = extend(den_raw, mode_d, tag_d[SIGN_BIT]);

`ifdef DIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q;
`else
    localparam int timeout_unused = DIV_TIMEOUT;
`endif

    always_ff @(posedge divider_clk or posedge divider_rst) begin
        if (divider_rst) begin
            state_q     <= ST_IDLE;
            i_call_q    <= 1'b0;
            reset_n_q   <= 1'b0;
            write_in_q  <= 1'b0;
            overflow_q  <= 1'b0;
            num_q       <= '0;
            den_q       <= '0;
            write_out_q <= '0;
`ifdef DIV_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            if (write && fifo_full) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                // A push landing this cycle is enough to leave IDLE.
                ST_IDLE: begin
                    if (!fifo_empty || push) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    num_q <= num_ext;
                    den_q <= den_ext;
                    if (bad_req) begin
                        write_out_q <= {TAG_W'(TAG_ERR), {DW{1'b0}}, TAG_W'(TAG_ERR), {DW{1'b0}}};
                        write_in_q  <= 1'b1;
                        state_q     <= ST_EMIT;
                    end else if (den_ext == '0) begin
                        write_out_q <= {TAG_W'(TAG_DZ), {DW{1'b1}}, TAG_W'(TAG_DZ), num_ext};
                        write_in_q  <= 1'b1;
                        state_q     <= ST_EMIT;
                    end else begin
                        i_call_q  <= 1'b1;
                        reset_n_q <= 1'b0;
                        state_q   <= ST_LAUNCH;
`ifdef DIV_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end
                end
                ST_LAUNCH: begin
                    reset_n_q <= 1'b1;
                    state_q   <= ST_WAIT;
`ifdef DIV_TIMEOUT_EN
                    wait_cnt_q <= CNT_W'(1);
`endif
                end
                ST_WAIT: begin
                    if (div_done) begin
                        i_call_q <= 1'b0;
                        state_q  <= ST_CAPTURE;
                    end
`ifdef DIV_TIMEOUT_EN
                    else if (wait_cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
                        i_call_q    <= 1'b0;
                        write_out_q <= {TAG_W'(TAG_ERR), {DW{1'b0}}, TAG_W'(TAG_ERR), {DW{1'b0}}};
                        write_in_q  <= 1'b1;
                        state_q     <= ST_EMIT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
`endif
                end
                ST_CAPTURE: begin
                    write_out_q <= {TAG_W'(TAG_Q), o_x, TAG_W'(TAG_R), o_y};
                    write_in_q  <= 1'b1;
                    state_q     <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        write_in_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_full     = fifo_full;
    assign overflow    = overflow_q;
    assign i_call      = i_call_q;
    assign reset_n     = reset_n_q;
    assign num_data    = num_q;
    assign dem_data    = den_q;
    assign write_in    = write_in_q;
    assign write_out   = write_out_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_divider_packet_ctrl.sv
// Directed bench for divider_packet_ctrl with a scoreboard on the result port.
// Timeout vectors are included when DIV_TIMEOUT_EN is defined.
module tb_divider_packet_ctrl;
    import divider_pkg::*;

    localparam int DW          = 32;
    localparam int TAG_W       = 16;
    localparam int PKT_W       = 2 * (TAG_W + DW);
    localparam int FIFO_DEPTH  = 4;
    localparam int DIV_TIMEOUT = 16;

    localparam logic [15:0] M4U = 16'h0400;
    localparam logic [15:0] M1U = 16'h0100;
    localparam logic [15:0] M1S = 16'h1100;

    logic             clk = 1'b0;
    logic             rst;
    logic             write;
    logic [PKT_W-1:0] out_data;
    logic             in_full;
    logic             overflow;
    logic             i_call;
    logic             reset_n;
    logic [DW-1:0]    num_data;
    logic [DW-1:0]    dem_data;
    logic [DW-1:0]    o_x = '0;
    logic [DW-1:0]    o_y = '0;
    logic             div_done = 1'b0;
    logic             write_in;
    logic [PKT_W-1:0] write_out;
    logic             out_ready;
    logic [2:0]       dbg_state;

    logic [PKT_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    bit model_stall  = 1'b0;
    bit model_signed = 1'b0;
    bit inject_done  = 1'b0;
    int model_lat    = 2;
    int wcnt         = 0;

    int unsigned b_q[4] = '{7, 7, 7, 8};
    int unsigned b_r[4] = '{0, 1, 2, 0};

    divider_packet_ctrl #(
        .DW          (DW),
        .TAG_W       (TAG_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .DIV_TIMEOUT (DIV_TIMEOUT)
    ) dut (
        .divider_clk (clk),
        .divider_rst (rst),
        .write       (write),
        .out_data    (out_data),
        .in_full     (in_full),
        .overflow    (overflow),
        .i_call      (i_call),
        .reset_n     (reset_n),
        .num_data    (num_data),
        .dem_data    (dem_data),
        .o_x         (o_x),
        .o_y         (o_y),
        .div_done    (div_done),
        .write_in    (write_in),
        .write_out   (write_out),
        .out_ready   (out_ready),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Divider core model: answers model_lat WAIT cycles after launch, holds o_x/o_y afterwards.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            div_done = 1'b0;
            wcnt     = 0;
        end else begin
            div_done = inject_done;
            if (i_call && !reset_n) begin
                wcnt = 0;
            end else if (i_call && reset_n) begin
                if (!model_stall && wcnt >= model_lat && dem_data != '0) begin
                    div_done = 1'b1;
                    if (model_signed) begin
                        o_x = $signed(num_data) / $signed(dem_data);
                        o_y = $signed(num_data) % $signed(dem_data);
                    end else begin
                        o_x = num_data / dem_data;
                        o_y = num_data % dem_data;
                    end
                end
                wcnt++;
            end
        end
    end

    task automatic report(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        report(name, PKT_W'(act), PKT_W'(exp));
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        report(name, PKT_W'(act), PKT_W'(exp));
    endtask

    task automatic check_dw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        report(name, PKT_W'(act), PKT_W'(exp));
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected packet.
    always @(negedge clk) begin
        if (!rst && write_in && out_ready) begin
            logic [PKT_W-1:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pkt: got 0x%0h, expected no packet", write_out);
            end else begin
                e = exp_q.pop_front();
                report("result_pkt", write_out, e);
            end
        end
    end

    function automatic logic [PKT_W-1:0] req(input logic [15:0] td, input logic [31:0] d,
                                             input logic [15:0] tn, input logic [31:0] n);
        return {td, d, tn, n};
    endfunction

    function automatic logic [PKT_W-1:0] res(input logic [15:0] t1, input logic [31:0] d1,
                                             input logic [15:0] t2, input logic [31:0] d2);
        return {t1, d1, t2, d2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PKT_W-1:0] pkt);
        write    = 1'b1;
        out_data = pkt;
        tick();
        write    = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (!write_in && lat < start + 100) begin
            tick();
            lat++;
        end
        if (!write_in) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: write_in low after %0d cycles, expected high", lat);
        end
    endtask

    task automatic wait_state(input logic [2:0] st);
        int n;
        n = 0;
        while (dbg_state != st && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || write_in || dbg_state != 3'(ST_IDLE)) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d packets still pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run still active at 300000, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic [PKT_W-1:0] hold_pkt;

        rst       = 1'b1;
        write     = 1'b0;
        out_data  = '0;
        out_ready = 1'b1;
        repeat (2) tick();

        check1("rst_i_call", i_call, 1'b0);
        check1("rst_reset_n", reset_n, 1'b0);
        check1("rst_write_in", write_in, 1'b0);
        check_dw("rst_num_data", num_data, '0);
        check_dw("rst_dem_data", dem_data, '0);
        report("rst_write_out", write_out, '0);
        check1("rst_in_full", in_full, 1'b0);
        check1("rst_overflow", overflow, 1'b0);
        check_int("rst_state", int'(dbg_state), int'(ST_IDLE));
        rst = 1'b0;
        tick();

        // Normal unsigned 100 / 7
        model_signed = 1'b0;
        exp_q.push_back(res(TAG_Q, 32'd14, TAG_R, 32'd2));
        send(req(M4U, 32'd7, M4U, 32'd100));
        tick();
        check1("launch_i_call", i_call, 1'b1);
        check1("launch_reset_n", reset_n, 1'b0);
        check_dw("norm_num_data", num_data, 32'd100);
        check_dw("norm_dem_data", dem_data, 32'd7);
        tick();
        check1("wait_reset_n", reset_n, 1'b1);
        check1("wait_i_call", i_call, 1'b1);
        wait_valid(3, lat);
        check_int("norm_latency", lat, 7);
        wait_drain();

        // Signed 8-bit -10 / 3, upper bytes of the numerator are junk
        model_signed = 1'b1;
        exp_q.push_back(res(TAG_Q, 32'hFFFF_FFFD, TAG_R, 32'hFFFF_FFFF));
        send(req(M1U, 32'h0000_0003, M1S, 32'h1234_56F6));
        tick();
        check_dw("s8_num_data", num_data, 32'hFFFF_FFF6);
        check_dw("s8_dem_data", dem_data, 32'h0000_0003);
        wait_drain();

        // Same operands, unsigned
        model_signed = 1'b0;
        exp_q.push_back(res(TAG_Q, 32'h52, TAG_R, 32'h0));
        send(req(M1U, 32'h0000_0003, M1U, 32'h1234_56F6));
        tick();
        check_dw("u8_num_data", num_data, 32'h0000_00F6);
        wait_drain();

        // Div-by-zero: plain zero, and a zero produced by the mode-1 selection
        exp_q.push_back(res(TAG_DZ, 32'hFFFF_FFFF, TAG_DZ, 32'd55));
        send(req(M4U, 32'd0, M4U, 32'd55));
        wait_valid(1, lat);
        check_int("dz_latency", lat, 2);
        check1("dz_no_call", i_call, 1'b0);
        wait_drain();
        exp_q.push_back(res(TAG_DZ, 32'hFFFF_FFFF, TAG_DZ, 32'd55));
        send(req(M1U, 32'h0000_0100, M4U, 32'd55));
        wait_valid(1, lat);
        check_int("dz_mask_latency", lat, 2);
        wait_drain();

        // Bad modes: 5 on the numerator, 0 on the denominator
        exp_q.push_back(res(TAG_ERR, 32'd0, TAG_ERR, 32'd0));
        send(req(M4U, 32'd7, 16'h0500, 32'd100));
        wait_valid(1, lat);
        check_int("bad5_latency", lat, 2);
        wait_drain();
        exp_q.push_back(res(TAG_ERR, 32'd0, TAG_ERR, 32'd0));
        send(req(16'h0000, 32'd7, M4U, 32'd100));
        wait_valid(1, lat);
        check_int("bad0_latency", lat, 2);
        wait_drain();

        // Stray div_done while idle
        inject_done = 1'b1;
        tick();
        inject_done = 1'b0;
        tick();
        check_int("stray_done_state", int'(dbg_state), int'(ST_IDLE));
        check1("stray_done_valid", write_in, 1'b0);

        // Backpressure: packet held for 10 cycles
        out_ready = 1'b0;
        hold_pkt  = res(TAG_DZ, 32'hFFFF_FFFF, TAG_DZ, 32'd9);
        exp_q.push_back(hold_pkt);
        send(req(M4U, 32'd0, M4U, 32'd9));
        wait_valid(1, lat);
        for (int i = 0; i < 10; i++) begin
            tick();
            report("hold_pkt", write_out, hold_pkt);
            check1("hold_valid", write_in, 1'b1);
        end
        out_ready = 1'b1;
        wait_drain();

        // Back-to-back: IDLE one cycle after handshake, LOAD the next
        out_ready = 1'b0;
        exp_q.push_back(res(TAG_DZ, 32'hFFFF_FFFF, TAG_DZ, 32'd1));
        exp_q.push_back(res(TAG_DZ, 32'hFFFF_FFFF, TAG_DZ, 32'd2));
        send(req(M4U, 32'd0, M4U, 32'd1));
        send(req(M4U, 32'd0, M4U, 32'd2));
        wait_valid(2, lat);
        out_ready = 1'b1;
        tick();
        check1("b2b_valid_drop", write_in, 1'b0);
        check_int("b2b_idle", int'(dbg_state), int'(ST_IDLE));
        tick();
        check_int("b2b_load", int'(dbg_state), int'(ST_LOAD));
        tick();
        check1("b2b_second_valid", write_in, 1'b1);
        wait_drain();

        // Overflow with the divider stalled
        model_stall = 1'b1;
        exp_q.push_back(res(TAG_Q, 32'd14, TAG_R, 32'd2));
        send(req(M4U, 32'd7, M4U, 32'd100));
        wait_state(3'(ST_WAIT));
        check_int("ovf_in_wait", int'(dbg_state), int'(ST_WAIT));
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(res(TAG_Q, b_q[i], TAG_R, b_r[i]));
            send(req(M4U, 32'd3, M4U, 32'(21 + i)));
        end
        check1("ovf_in_full", in_full, 1'b1);
        check1("ovf_not_yet", overflow, 1'b0);
        send(req(M4U, 32'd9, M4U, 32'd99));
        check1("ovf_set", overflow, 1'b1);
        model_stall = 1'b0;
        wait_drain();
        check1("ovf_sticky", overflow, 1'b1);
        check1("ovf_full_clear", in_full, 1'b0);

        // Reset mid-WAIT with one request still queued
        model_stall = 1'b1;
        send(req(M4U, 32'd7, M4U, 32'd100));
        wait_state(3'(ST_WAIT));
        send(req(M4U, 32'd0, M4U, 32'd5));
        check1("mid_wait_call", i_call, 1'b1);
        rst = 1'b1;
        #1;
        check1("arst_i_call", i_call, 1'b0);
        check1("arst_reset_n", reset_n, 1'b0);
        check1("arst_write_in", write_in, 1'b0);
        check_dw("arst_num_data", num_data, '0);
        check_dw("arst_dem_data", dem_data, '0);
        report("arst_write_out", write_out, '0);
        check1("arst_overflow", overflow, 1'b0);
        check_int("arst_state", int'(dbg_state), int'(ST_IDLE));
        tick();
        rst = 1'b0;
        model_stall = 1'b0;
        repeat (6) tick();
        check_int("post_rst_state", int'(dbg_state), int'(ST_IDLE));
        check1("post_rst_valid", write_in, 1'b0);

`ifdef DIV_TIMEOUT_EN
        // Watchdog: no div_done, error packet 16 cycles after LAUNCH
        model_stall = 1'b1;
        exp_q.push_back(res(TAG_ERR, 32'd0, TAG_ERR, 32'd0));
        send(req(M4U, 32'd7, M4U, 32'd100));
        tick();
        check_int("to_launch_state", int'(dbg_state), int'(ST_LAUNCH));
        wait_valid(2, lat);
        check_int("to_latency", lat - 2, DIV_TIMEOUT);
        check1("to_call_low", i_call, 1'b0);
        wait_drain();
        inject_done = 1'b1;
        tick();
        inject_done = 1'b0;
        repeat (4) tick();
        check_int("to_late_done_state", int'(dbg_state), int'(ST_IDLE));
        check1("to_late_done_valid", write_in, 1'b0);
        model_stall = 1'b0;
`endif

        repeat (3) tick();
        check_int("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
